// File: rtl/tcm_exec_ctrl_if.sv
// Board/core-side signal bundle of the two-counter machine execution controller.
// The controller attaches through the slave modport, the board/core side through master.
interface tcm_exec_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             clockButton;
  logic             run;
  logic             clear;
  logic             halt;
  logic [7:0]       pc;
  logic [7:0]       bp_addr;
  logic             bp_en;
  logic             core_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycles;
  logic [1:0]       stop_cause;

  modport master (
    output clockButton, run, clear, halt, pc, bp_addr, bp_en,
    input  core_en, state, cycles, stop_cause
  );

  modport slave (
    input  clockButton, run, clear, halt, pc, bp_addr, bp_en,
    output core_en, state, cycles, stop_cause
  );
endinterface

// File: rtl/tcm_exec_ctrl.sv
// Execution controller: free-run, debounced single-step, PC breakpoint, HALT stop.
// Optional run-length watchdog is built only when TCM_CTRL_WDOG_EN is defined.
module tcm_exec_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_RUN         = 1000,
  parameter int CNT_W           = 16
) (
  input logic             CLK,
  input logic             reset,
  tcm_exec_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    STOPPED = 2'd3
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           st;
  logic [1:0]       cause;
  logic [CNT_W-1:0] cycles;
  logic             bp_skip;
  logic             bp_hit;
  logic             wd_hit;
  logic             en;

  logic             btn_p0, btn_p1;
  logic             db_level;
  logic [DB_W-1:0]  db_cnt;
  logic             step_req;

  // Stage p0/p1: two-flop synchronizer, then a level must hold for DEBOUNCE_CYCLES samples
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      btn_p0   <= 1'b0;
      btn_p1   <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else begin
      btn_p0   <= bus.clockButton;
      btn_p1   <= btn_p0;
      step_req <= 1'b0;
      if (btn_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt   <= '0;
        db_level <= btn_p1;
        step_req <= btn_p1;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

`ifdef TCM_CTRL_WDOG_EN
  localparam int RL_W = $clog2(MAX_RUN + 1);
  logic [RL_W-1:0] run_len;

  assign wd_hit = (run_len == RL_W'(MAX_RUN));

  // Re-armed on every IDLE cycle so each RUN episode starts its budget from zero
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      run_len <= '0;
    end else if (bus.clear || st == IDLE) begin
      run_len <= '0;
    end else if (st == RUN && en) begin
      run_len <= run_len + RL_W'(1);
    end
  end
`else
  logic unused_max_run;
  assign unused_max_run = (MAX_RUN == 0);
  assign wd_hit         = 1'b0;
`endif

  assign bp_hit = bus.bp_en & (bus.pc == bus.bp_addr) & ~bp_skip;

  always_comb begin
    en = 1'b0;
    case (st)
      RUN:     en = bus.run & ~bus.halt & ~bp_hit & ~wd_hit;
      STEP:    en = ~bus.halt;
      default: en = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      st      <= IDLE;
      cause   <= 2'd0;
      cycles  <= '0;
      bp_skip <= 1'b0;
    end else begin
      if (bus.clear)  cycles <= '0;
      else if (en)    cycles <= sat_inc(cycles);

      case (st)
        IDLE: begin
          if (bus.clear) begin
            cause <= 2'd0;
          end else if (bus.halt) begin
            st    <= STOPPED;
            cause <= 2'd1;
          end else if (bus.run) begin
            st      <= RUN;
            bp_skip <= 1'b1;
          end else if (step_req) begin
            st <= STEP;
          end
        end
        RUN: begin
          // Skip only the entry cycle, so a resume from the breakpoint PC moves on
          bp_skip <= 1'b0;
          if (bus.clear) begin
            st    <= IDLE;
            cause <= 2'd0;
          end else if (bus.halt) begin
            st    <= STOPPED;
            cause <= 2'd1;
          end else if (bp_hit) begin
            st    <= STOPPED;
            cause <= 2'd2;
          end else if (wd_hit) begin
            st    <= STOPPED;
            cause <= 2'd3;
          end else if (!bus.run) begin
            st <= IDLE;
          end
        end
        STEP: begin
          if (bus.clear) begin
            st    <= IDLE;
            cause <= 2'd0;
          end else if (bus.halt) begin
            st    <= STOPPED;
            cause <= 2'd1;
          end else begin
            st <= IDLE;
          end
        end
        STOPPED: begin
          if (bus.clear) begin
            st    <= IDLE;
            cause <= 2'd0;
          end else if (cause == 2'd2 && step_req) begin
            st    <= STEP;
            cause <= 2'd0;
          end
        end
      endcase
    end
  end

  assign bus.core_en    = en;
  assign bus.state      = st;
  assign bus.cycles     = cycles;
  assign bus.stop_cause = cause;

endmodule

// File: doc/tcm_exec_ctrl.md
Name: tcm_exec_ctrl

Overview:
- Execution controller for the two-counter machine core.
- Produces the single enable `core_en` that gates PC advance, register-file writeback and iram fetch.
- Supports free-run, debounced single-step from the clock button, PC breakpoint, HALT detection and a run-length watchdog.
- Sits between the board inputs and the core; the core advances only on cycles where `core_en`=1.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a button level change.
- MAX_RUN, 1000: enabled cycles allowed in one RUN episode before the watchdog stops execution.
- CNT_W, 16: width of the `cycles` counter.

Ports:
- CLK  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clockButton  in  1  raw pushbutton, pressed=1, asynchronous to CLK.
- run  in  1  level request for free-run.
- clear  in  1  synchronous; returns to IDLE and zeroes counters and cause.
- halt  in  1  from decoder; current instruction is HALT.
- pc  in  8  current program counter.
- bp_addr  in  8  breakpoint address.
- bp_en  in  1  breakpoint enable.
- core_en  out  1  core advance enable, combinational from state and inputs.
- state  out  2  IDLE=0, RUN=1, STEP=2, STOPPED=3.
- cycles  out  CNT_W  total enabled cycles, saturating.
- stop_cause  out  2  0=none, 1=halt, 2=breakpoint, 3=watchdog.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cycles=0, stop_cause=0, debounce state cleared (debounced level=0), run_len=0, bp_skip=0; `core_en`=0.
- Button path:
  - 2-flop synchronizer, then a counter that must see the new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes.
  - `step_req` is a 1-cycle pulse on the debounced 0->1 edge. Press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
- `bp_hit` = bp_en & (pc==bp_addr) & ~bp_skip.
- IDLE: `core_en`=0. Priority order:
  - clear: stay IDLE.
  - halt: go to STOPPED, cause=1.
  - run: go to RUN; set bp_skip=1, run_len=0.
  - step_req: go to STEP.
- RUN:
  - `core_en` = run & ~halt & ~bp_hit & ~wd_hit, where wd_hit = (run_len==MAX_RUN).
  - Next state, in priority order:
    - clear: go to IDLE.
    - halt: go to STOPPED, cause=1.
    - bp_hit: go to STOPPED, cause=2.
    - wd_hit: go to STOPPED, cause=3.
    - ~run: go to IDLE.
    - otherwise stay in RUN.
  - bp_skip clears after the first RUN cycle. This allows resuming from a breakpoint PC.
  - run_len increments on each enabled cycle.
- STEP: `core_en` = ~halt for exactly one cycle, then IDLE. If halt=1, go to STOPPED with cause=1 instead.
- STOPPED: `core_en`=0.
  - clear: go to IDLE, cause=0.
  - cause==2 and step_req: go to STEP, cause=0 (step past breakpoint).
  - All other inputs are ignored.
- cycles: +1 on every cycle with `core_en`=1; saturates at all ones; zeroed by clear.
- step_req arriving in RUN is dropped.
- run toggling mid-STEP has no effect until IDLE.
- Async reset mid-RUN forces IDLE immediately; `core_en` drops in the same cycle.

Optional Feature:
- Macro TCM_CTRL_WDOG_EN.
- Defined: run_len counter present; watchdog behaves as described.
- Undefined: run_len removed, wd_hit constant 0, stop_cause never 3, MAX_RUN unused.

Test Plan:
- Reset, then run=1 with halt asserted when pc=5 (start pc=0) -> `core_en`=1 for 5 cycles, state=STOPPED, stop_cause=1, cycles=5.
- Button held 1 for 20 cycles, DEBOUNCE_CYCLES=16 -> exactly one STEP; `core_en`=1 for 1 cycle; cycles=1.
- Button glitch of 10 cycles -> no STEP; cycles unchanged.
- bp_en=1, bp_addr=3, run=1 -> stop at pc=3 with cause=2 and cycles=3. Then clear with run still 1 -> RUN resumes past pc=3 without re-triggering.
- Watchdog:
  - TCM_CTRL_WDOG_EN defined, MAX_RUN=10, run=1, no halt -> STOPPED after exactly 10 enabled cycles, cause=3.
  - Macro undefined -> RUN continues past 10 cycles.
- reset pulled low during RUN at cycles=7 -> `core_en`=0 immediately, state=IDLE, cycles=0, stop_cause=0.
